// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//   Two-master, one-slave arbiter for a pipelined Wishbone memory bus.
//   Master 0 is instruction fetch. Master 1 is the load-store module (LSM).
//   A grant lasts for a whole bus cycle (CYC high). It is released only after
//   every accepted strobe has been acknowledged. Every release is followed by
//   one IDLE cycle before any new grant.
//
//   Parameters
//     MAX_OUTSTANDING : accepted-but-unacknowledged requests per grant (1..15)
//     CNT_W           : outstanding counter width (must hold MAX_OUTSTANDING)
//
//   Optional build macro
//     WB_ARBITER_ROUND_ROBIN_EN : when both masters request in IDLE, grant
//                                 the master that was not granted last.
//                                 When the macro is undefined, m1 always
//                                 wins a simultaneous request.
//
//   Ports
//     clk_i, rst_i          clock; asynchronous active-low reset
//     m0_wb_* / m1_wb_*     master-side Wishbone (adr/dat/we/sel/stb/cyc in,
//                           ack/stall out)
//     m_wb_dat_o            slave read data, broadcast to both masters
//     wb_*_o / wb_*_i       slave-side Wishbone port
// ---------------------------------------------------------------------------
module wb_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_wb_adr_i,
  input  logic [31:0] m0_wb_dat_i,
  input  logic        m0_wb_we_i,
  input  logic [3:0]  m0_wb_sel_i,
  input  logic        m0_wb_stb_i,
  input  logic        m0_wb_cyc_i,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_stall_o,
  input  logic [31:0] m1_wb_adr_i,
  input  logic [31:0] m1_wb_dat_i,
  input  logic        m1_wb_we_i,
  input  logic [3:0]  m1_wb_sel_i,
  input  logic        m1_wb_stb_i,
  input  logic        m1_wb_cyc_i,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_stall_o,
  output logic [31:0] m_wb_dat_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_stall_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_M0 = 2'd1,
    GNT_M1 = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic gnt_m0, gnt_m1, granted;
  logic own_cyc, own_stb;
  logic cnt_full, accept;

`ifdef WB_ARBITER_ROUND_ROBIN_EN
  // 0 = master 0 was granted last, 1 = master 1 was granted last.
  logic last_grant_q, last_grant_d;
`endif

  assign gnt_m0   = (state_q == GNT_M0);
  assign gnt_m1   = (state_q == GNT_M1);
  assign granted  = gnt_m0 | gnt_m1;
  assign cnt_full = (cnt_q == MAX_CNT);

  // Slave-side request mux: the owner's signals pass through, IDLE drives zeros.
  always_comb begin
    wb_adr_o = '0;
    wb_dat_o = '0;
    wb_we_o  = 1'b0;
    wb_sel_o = '0;
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    if (gnt_m0) begin
      wb_adr_o = m0_wb_adr_i;
      wb_dat_o = m0_wb_dat_i;
      wb_we_o  = m0_wb_we_i;
      wb_sel_o = m0_wb_sel_i;
      own_cyc  = m0_wb_cyc_i;
      own_stb  = m0_wb_stb_i;
    end else if (gnt_m1) begin
      wb_adr_o = m1_wb_adr_i;
      wb_dat_o = m1_wb_dat_i;
      wb_we_o  = m1_wb_we_i;
      wb_sel_o = m1_wb_sel_i;
      own_cyc  = m1_wb_cyc_i;
      own_stb  = m1_wb_stb_i;
    end
  end

  // CYC stays high after the owner drops its CYC until the last ack has
  // drained. STB is masked whenever the outstanding window is full.
  assign wb_cyc_o = granted;
  assign wb_stb_o = granted & own_stb & own_cyc & (cnt_q < MAX_CNT);
  assign accept   = wb_stb_o & ~wb_stall_i;

  // Stall is built from the registered count only. This keeps wb_ack_i off
  // every combinational path to a stall output.
  assign m0_wb_stall_o = gnt_m0 ? (wb_stall_i | cnt_full) : 1'b1;
  assign m1_wb_stall_o = gnt_m1 ? (wb_stall_i | cnt_full) : 1'b1;
  assign m0_wb_ack_o   = gnt_m0 & wb_ack_i;
  assign m1_wb_ack_o   = gnt_m1 & wb_ack_i;
  assign m_wb_dat_o    = wb_dat_i;

  // Outstanding count. An accept and an ack in the same cycle cancel out.
  // A stray ack with nothing outstanding is ignored.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && !wb_ack_i) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!accept && wb_ack_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Next-state logic. Release checks the count after this cycle's ack.
  always_comb begin
    state_d = state_q;
`ifdef WB_ARBITER_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (m0_wb_cyc_i && m1_wb_cyc_i) begin
`ifdef WB_ARBITER_ROUND_ROBIN_EN
          state_d = last_grant_q ? GNT_M0 : GNT_M1;
`else
          state_d = GNT_M1;
`endif
        end else if (m1_wb_cyc_i) begin
          state_d = GNT_M1;
        end else if (m0_wb_cyc_i) begin
          state_d = GNT_M0;
        end
`ifdef WB_ARBITER_ROUND_ROBIN_EN
        if (state_d == GNT_M0) begin
          last_grant_d = 1'b0;
        end else if (state_d == GNT_M1) begin
          last_grant_d = 1'b1;
        end
`endif
      end
      GNT_M0: if (!m0_wb_cyc_i && (cnt_d == '0)) state_d = IDLE;
      GNT_M1: if (!m1_wb_cyc_i && (cnt_d == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef WB_ARBITER_ROUND_ROBIN_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_grant_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Two-master, one-slave arbiter for the pipelined Wishbone memory bus. Master 0 is instruction fetch; master 1 is the load-store module (LSM). Grants are held for a whole bus cycle (CYC high) and released only once every accepted strobe has been acknowledged. Sits between the fetch/LSM Wishbone masters and the single memory-side port of the core.

Parameters:
MAX_OUTSTANDING, 4, maximum accepted-but-unacknowledged requests per grant (1..15).
CNT_W, 4, outstanding counter width; must hold MAX_OUTSTANDING.

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  reset, asynchronous, active-low
m0_wb_adr_i  in  32  master 0 address
m0_wb_dat_i  in  32  master 0 write data
m0_wb_we_i  in  1  master 0 write enable
m0_wb_sel_i  in  4  master 0 byte select
m0_wb_stb_i  in  1  master 0 strobe
m0_wb_cyc_i  in  1  master 0 cycle
m0_wb_ack_o  out  1  master 0 acknowledge
m0_wb_stall_o  out  1  master 0 stall
m1_wb_*  same set as m0 for master 1 (LSM)
m_wb_dat_o  out  32  read data, broadcast to both masters
wb_adr_o  out  32  slave address
wb_dat_o  out  32  slave write data
wb_we_o  out  1  slave write enable
wb_sel_o  out  4  slave byte select
wb_stb_o  out  1  slave strobe
wb_cyc_o  out  1  slave cycle
wb_dat_i  in  32  slave read data
wb_ack_i  in  1  slave acknowledge
wb_stall_i  in  1  slave stall

Behaviour:
- State register: IDLE, GNT_M0, GNT_M1. Outstanding counter cnt is CNT_W bits.
- Reset: rst_i low asynchronously forces state=IDLE and cnt=0.
- Output values while in reset or IDLE: wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o/wb_dat_o/wb_sel_o=0, m*_ack_o=0, m*_stall_o=1.
- IDLE -> GNT_x at a clock edge when mx_wb_cyc_i=1. Arbitration costs one cycle: the granted master sees stall=0 from the next cycle on.
- Simultaneous request, default policy: fixed priority, m1 (LSM) wins.
- GNT_x -> IDLE when mx_wb_cyc_i=0 and cnt==0 (counted after this cycle's ack). There is no direct handoff; a one-cycle IDLE bubble always follows.
- While in GNT_x:
  - Slave address, data, we and sel are driven from master x.
  - wb_cyc_o=1.
  - wb_stb_o = mx_wb_stb_i & mx_wb_cyc_i & (cnt<MAX_OUTSTANDING).
- Stall rules:
  - mx_wb_stall_o = wb_stall_i | (cnt==MAX_OUTSTANDING).
  - The non-granted master's stall is always 1.
- Ack rules: wb_ack_i is routed only to the granted master's ack; the other master's ack is 0. m_wb_dat_o = wb_dat_i unconditionally.
- Counter:
  - +1 on accept (wb_stb_o & !wb_stall_i).
  - -1 on wb_ack_i.
  - Both in the same cycle: unchanged.
  - Ack with cnt==0: ignored, cnt saturates at 0.
  - Never exceeds MAX_OUTSTANDING.
- Owner drops cyc with cnt>0: wb_cyc_o stays 1 and wb_stb_o=0 until the remaining acks arrive. Those acks are still forwarded to the owner.
- Non-owner raising cyc mid-grant waits with stall=1; its request is evaluated in IDLE.
- Reset asserted mid-transfer: the grant is dropped immediately and in-flight acks are lost. Masters are reset by the same signal.
- Slave outputs are combinational from the state and the granted master's inputs. No combinational path from wb_ack_i to any stall output.

Optional Feature:
- Macro WB_ARBITER_ROUND_ROBIN_EN.
- Defined: one-bit last_grant register, reset value 0 (master 0). On simultaneous request in IDLE, grant goes to the master not granted last. last_grant updates on every IDLE->GNT transition.
- Undefined: fixed priority, m1 wins. No last_grant register is present.

Test Plan:
1. Reset, no requests -> wb_cyc_o=0, m0/m1 stall=1 and ack=0 after release. State stays IDLE for 10 cycles.
2. m0 single read adr=0x0000_1000, slave acks 2 cycles after accept with dat=0xDEAD_BEEF -> m0_ack_o=1 with m_wb_dat_o=0xDEAD_BEEF. m1_ack_o stays 0. Return to IDLE one cycle after m0 drops cyc.
3. m0 and m1 assert cyc in the same cycle, m1 write adr=0x2000 dat=0x1234_5678 sel=0xF -> slave sees the m1 write first and m0 stall=1 throughout. m0 is granted after m1 releases plus one IDLE cycle.
4. m0 issues 6 back-to-back strobes, slave stall=0, acks withheld -> 4 accepted, then m0_stall_o=1 with cnt=4. Each ack accepts exactly one more strobe.
5. m1 drops cyc with 2 outstanding while m0 requests -> wb_cyc_o=1 and wb_stb_o=0 until 2 acks reach m1. m0 is granted afterwards.
6. With WB_ARBITER_ROUND_ROBIN_EN, both request continuously with single-access cycles -> grants alternate m1, m0, m1, m0. Without the macro, m1 is granted each time.
